alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 32-bit combinational ALU between two requesters: req0, the main execute path, and req1, the address/branch-compare path.
- Round-robin grant, valid/ready handshake on each request port, one operation in flight at a time.
- Registers operands and fn toward the ALU and holds them stable while the result settles; MUL gets an extra multi-cycle allowance.
- Returns result/zero/overflow on one shared response channel tagged with the requester id.

Parameters:
- WIDTH, 32, operand/result width.
- FN_W, 6, ALU function code width.
- MUL_CYCLES, 2, extra settle cycles allowed for fn 000010 (mul); legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0_valid / req1_valid  input  1  request present.
- req0_ready / req1_ready  output  1  arbiter accepts that request this cycle.
- req0_a / req1_a  input  WIDTH  operand A (ALU i0).
- req0_b / req1_b  input  WIDTH  operand B (ALU i1).
- req0_fn / req1_fn  input  FN_W  ALU function code.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes response.
- rsp_id  output  1  requester that owns the response.
- rsp_result  output  WIDTH  ALU otp.
- rsp_zero  output  1  ALU zero.
- rsp_ovf  output  1  ALU ovrflo.
- rsp_err  output  1  illegal fn code.
- alu_i0 / alu_i1  output  WIDTH  registered operands to ALU.
- alu_fn  output  FN_W  registered fn to ALU.
- alu_otp  input  WIDTH  ALU result.
- alu_zero  input  1  ALU zero flag.
- alu_ovrflo  input  1  ALU overflow flag.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE; last_grant=1, so req0 wins the first tie.
  - All outputs 0: rsp_*, alu_i0/i1/fn (fn 0 = add), busy, cnt.
  - Reset mid-operation abandons the op; no response is ever issued for it.
- Legal fn set: 000000 add, 000001 sub, 000010 mul, 000100 and, 000101 or, 000110 xor, 001000 sll, 001001 srl, 001011 slt. Every other code is illegal.
- Ready logic (combinational from state/last_grant/valids):
  - reqN_ready=1 only in IDLE, and only for the granted N.
  - Grant: if only one valid, grant it. If both valid, grant the requester != last_grant.
  - Ready is never asserted for a requester whose valid is low.
- Handshake: request accepted at an edge where valid&ready=1. Operands/fn are sampled only then; the requester must hold them stable until accepted.
- IDLE:
  - On accept, latch a→alu_i0, b→alu_i1, fn→alu_fn, id→op_id; last_grant←id.
  - Load cnt=MUL_CYCLES if fn=mul, else 0; set err_q = illegal(fn).
  - → EXEC.
- EXEC:
  - cnt!=0: decrement, stay.
  - cnt==0: capture rsp_result←alu_otp, rsp_zero←alu_zero, rsp_ovf←alu_ovrflo, rsp_err←0, rsp_id←op_id; → RESP.
  - If err_q: capture result 0, zero 0, ovf 0, err 1 instead; still spends the cnt==0 EXEC cycle.
- RESP:
  - rsp_valid=1; all rsp_* held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: rsp_valid←0, → IDLE.
  - The next accept happens at the earliest one cycle after the response handshake; no overlap.
- Latency, accept edge = T:
  - Non-mul: rsp_valid high in cycle T+2.
  - Mul: rsp_valid high in cycle T+2+MUL_CYCLES.
  - Throughput with rsp_ready tied high: one op per 3 (+MUL_CYCLES) cycles.
- alu_i0/i1/fn change only on accept. They keep their last values in IDLE and RESP, so no ALU input glitches mid-op.
- Fairness: under continuous valid on both ports, grants strictly alternate 0,1,0,1. A single active requester gets back-to-back grants.
- Width rules: no arithmetic in this block. Results and flags pass through unmodified; shift amounts and overflow semantics are the ALU's.

Test Plan:
- req0 a=7 b=5 fn=000000, rsp_ready=1 → req0_ready at accept, rsp_valid at T+2, rsp_id=0, result=12, zero=0, err=0; busy high T+1..T+2.
- req1 a=9 b=9 fn=000001 → rsp_id=1, result=0, zero=1 at T+2.
- MUL_CYCLES=2, req0 a=3 b=4 fn=000010 → rsp_valid first high at T+4, result=12; alu_i0/i1 stable over T+1..T+4.
- After reset, req0 and req1 both held valid with add ops (1+1, 2+2) → grants 0,1,0,1; responses id0=2, id1=4 in that order; neither ready high while busy.
- rsp_ready low 5 cycles in RESP → rsp_* constant, both reqN_ready=0; next accept one cycle after the rsp handshake.
- fn=000011 (illegal) → result=0, zero=0, ovf=0, err=1 at T+2. Separately, rst=1 during EXEC of a mul → next cycle state IDLE, all outputs 0, no rsp_valid ever for that op.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters
// clk/rst: rising-edge clock, synchronous active-high reset
// req0_*/req1_*: request ports (valid/ready, operands a/b, fn); req0 is execute, req1 is address/branch
// rsp_*: shared response channel (valid/ready, id, result, zero, ovf, err)
// alu_i0/alu_i1/alu_fn: registered ALU inputs; alu_otp/alu_zero/alu_ovrflo: ALU outputs
// busy: an operation is in flight or its response is pending
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int FN_W       = 6,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [FN_W-1:0]  req0_fn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [FN_W-1:0]  req1_fn,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_i0,
  output logic [WIDTH-1:0] alu_i1,
  output logic [FN_W-1:0]  alu_fn,
  input  logic [WIDTH-1:0] alu_otp,
  input  logic             alu_zero,
  input  logic             alu_ovrflo,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [FN_W-1:0] FN_MUL = FN_W'(2);
  state_t state, state_n;
  logic last_grant, grant, acc, op_id, err_q;
  logic [3:0] cnt;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [FN_W-1:0] fn_sel;
  function automatic logic legal(input logic [FN_W-1:0] f);
    return f inside {FN_W'(0), FN_W'(1), FN_W'(2), FN_W'(4), FN_W'(5), FN_W'(6), FN_W'(8), FN_W'(9), FN_W'(11)};
  endfunction
  // on a tie the requester that did not win last time gets the ALU
  assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign acc        = req0_ready || req1_ready;
  assign a_sel      = grant ? req1_a : req0_a;
  assign b_sel      = grant ? req1_b : req0_b;
  assign fn_sel     = grant ? req1_fn : req0_fn;
  assign rsp_valid  = state == RESP;
  assign busy       = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? EXEC : IDLE;
      EXEC:    state_n = cnt == 4'd0 ? RESP : EXEC;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      err_q      <= 1'b0;
      cnt        <= 4'd0;
      alu_i0     <= '0;
      alu_i1     <= '0;
      alu_fn     <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        alu_i0     <= a_sel;
        alu_i1     <= b_sel;
        alu_fn     <= fn_sel;
        op_id      <= grant;
        last_grant <= grant;
        cnt        <= fn_sel == FN_MUL ? 4'(MUL_CYCLES) : 4'd0;
        err_q      <= !legal(fn_sel);
      end
      if (state == EXEC) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          rsp_result <= err_q ? '0 : alu_otp;
          rsp_zero   <= !err_q && alu_zero;
          rsp_ovf    <= !err_q && alu_ovrflo;
          rsp_err    <= err_q;
          rsp_id     <= op_id;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU stub
module tb_alu_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [5:0] req0_fn = 0, req1_fn = 0;
  logic rsp_valid, rsp_ready = 1, rsp_id, rsp_zero, rsp_ovf, rsp_err, busy;
  logic [31:0] rsp_result, alu_i0, alu_i1, alu_otp;
  logic [5:0] alu_fn;
  logic alu_zero, alu_ovrflo;
  int n_chk = 0, n_err = 0;
  int lat;
  always #5 clk = ~clk;
  alu_arbiter #(.WIDTH(32), .FN_W(6), .MUL_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fn(req0_fn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fn(req1_fn),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .alu_i0(alu_i0), .alu_i1(alu_i1), .alu_fn(alu_fn),
    .alu_otp(alu_otp), .alu_zero(alu_zero), .alu_ovrflo(alu_ovrflo), .busy(busy)
  );
  always_comb begin
    alu_otp    = 32'hdeadbeef;
    alu_ovrflo = 1'b1;
    case (alu_fn)
      6'd0: begin
        alu_otp    = alu_i0 + alu_i1;
        alu_ovrflo = (alu_i0[31] == alu_i1[31]) && (alu_otp[31] != alu_i0[31]);
      end
      6'd1: begin alu_otp = alu_i0 - alu_i1; alu_ovrflo = 1'b0; end
      6'd2: begin alu_otp = alu_i0 * alu_i1; alu_ovrflo = 1'b0; end
      6'd4: begin alu_otp = alu_i0 & alu_i1; alu_ovrflo = 1'b0; end
      6'd5: begin alu_otp = alu_i0 | alu_i1; alu_ovrflo = 1'b0; end
      6'd6: begin alu_otp = alu_i0 ^ alu_i1; alu_ovrflo = 1'b0; end
      default: ;
    endcase
    alu_zero = alu_otp == 32'd0;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic run(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [5:0] fn, output int l);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_fn = fn; end
    else begin req0_valid = 1; req0_a = a; req0_b = b; req0_fn = fn; end
    #1;
    chk("ready", id ? req1_ready : req0_ready, 1);
    chk("ready_other", id ? req0_ready : req1_ready, 0);
    tick;
    req0_valid = 0;
    req1_valid = 0;
    l = 1;
    chk("busy_exec", busy, 1);
    while (!rsp_valid && l < 30) begin
      chk("hold_i0", alu_i0, a);
      chk("hold_i1", alu_i1, b);
      tick;
      l++;
    end
    chk("rsp_seen", rsp_valid, 1);
    chk("busy_resp", busy, 1);
    chk("hold_i0_resp", alu_i0, a);
    chk("rsp_id", rsp_id, id);
  endtask
  initial begin
    int g0, g1, ng, nr;
    logic [3:0] grants, ids;
    tick; tick;
    rst = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_i0", alu_i0, 0);
    chk("rst_fn", alu_fn, 0);
    run(0, 7, 5, 6'd0, lat);
    chk("add_lat", lat, 2);
    chk("add_res", rsp_result, 12);
    chk("add_zero", rsp_zero, 0);
    chk("add_err", rsp_err, 0);
    tick;
    chk("add_idle", busy, 0);
    run(1, 9, 9, 6'd1, lat);
    chk("sub_lat", lat, 2);
    chk("sub_res", rsp_result, 0);
    chk("sub_zero", rsp_zero, 1);
    tick;
    run(0, 3, 4, 6'd2, lat);
    chk("mul_lat", lat, 4);
    chk("mul_res", rsp_result, 12);
    tick;
    run(1, 32'h7fffffff, 1, 6'd0, lat);
    chk("ovf_res", rsp_result, 32'h80000000);
    chk("ovf_flag", rsp_ovf, 1);
    tick;
    run(0, 5, 6, 6'd3, lat);
    chk("ill_lat", lat, 2);
    chk("ill_res", rsp_result, 0);
    chk("ill_zero", rsp_zero, 0);
    chk("ill_ovf", rsp_ovf, 0);
    chk("ill_err", rsp_err, 1);
    tick;
    run(0, 32'hf0, 32'h3c, 6'd6, lat);
    chk("xor_res", rsp_result, 32'hcc);
    chk("xor_err", rsp_err, 0);
    tick;
    // fairness after a fresh reset: both ports held valid
    rst = 1; tick; rst = 0;
    req0_a = 1; req0_b = 1; req0_fn = 0;
    req1_a = 2; req1_b = 2; req1_fn = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    ng = 0; nr = 0; grants = 0; ids = 0;
    for (int c = 0; c < 60 && (ng < 4 || nr < 4); c++) begin
      if (busy && (req0_ready || req1_ready)) chk("ready_while_busy", {req0_ready, req1_ready}, 0);
      if (req0_ready && req1_ready) chk("dual_ready", 1, 0);
      if ((req0_ready || req1_ready) && ng < 4) begin grants[ng] = req1_ready; ng++; end
      if (rsp_valid && nr < 4) begin
        ids[nr] = rsp_id;
        chk("fair_res", rsp_result, rsp_id ? 32'd4 : 32'd2);
        nr++;
      end
      tick;
      #1;
    end
    req0_valid = 0; req1_valid = 0;
    chk("fair_ng", ng, 4);
    chk("fair_nr", nr, 4);
    chk("fair_grants", {28'd0, grants}, 32'b1010);
    chk("fair_ids", {28'd0, ids}, 32'b1010);
    tick; tick; tick; tick;
    // response backpressure
    rsp_ready = 0;
    run(0, 10, 3, 6'd1, lat);
    req1_valid = 1; req1_a = 1; req1_b = 2; req1_fn = 6'd5;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_res", rsp_result, 7);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready", {req0_ready, req1_ready}, 0);
      tick;
    end
    rsp_ready = 1;
    #1;
    chk("bp_ready_hs", req1_ready, 0);
    tick;
    rsp_ready = 0;
    #1;
    chk("bp_next_accept", req1_ready, 1);
    chk("bp_idle", rsp_valid, 0);
    tick;
    req1_valid = 0;
    rsp_ready = 1;
    lat = 1;
    while (!rsp_valid && lat < 30) begin tick; lat++; end
    chk("bp2_lat", lat, 2);
    chk("bp2_res", rsp_result, 3);
    chk("bp2_id", rsp_id, 1);
    tick;
    // reset during a mul's EXEC phase
    req0_valid = 1; req0_a = 6; req0_b = 7; req0_fn = 6'd2;
    tick;
    req0_valid = 0;
    tick;
    chk("mr_busy_pre", busy, 1);
    rst = 1;
    tick;
    rst = 0;
    chk("mr_busy", busy, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_i0", alu_i0, 0);
    chk("mr_i1", alu_i1, 0);
    chk("mr_fn", alu_fn, 0);
    chk("mr_res", rsp_result, 0);
    chk("mr_flags", {rsp_id, rsp_zero, rsp_ovf, rsp_err}, 0);
    g0 = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) g0++;
      tick;
    end
    chk("mr_no_rsp", g0, 0);
    g1 = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
